// File: rtl/regfile_writer.sv
// Write-side sequencer for the 32x64 register file: queues MEM/WB results,
// drains them through the single write port and forwards pending values.
module regfile_writer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regWrite,
    input  logic [4:0]        in_dest,
    input  logic              in_memToReg,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic              ext_wr_req,
    input  logic [4:0]        ext_wr_reg,
    input  logic [DATA_W-1:0] ext_wr_data,
    output logic              RegWrite,
    output logic [4:0]        WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    input  logic [DATA_W-1:0] RfData1,
    input  logic [DATA_W-1:0] RfData2,
    output logic [DATA_W-1:0] FwdData1,
    output logic [DATA_W-1:0] FwdData2,
    output logic              pending
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]        qdest [DEPTH];
    logic [DATA_W-1:0] qdata [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;

    logic              empty;
    logic              full;
    logic              drain;
    logic              push;
    logic [DATA_W-1:0] in_data;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign drain    = ~reset & ~ext_wr_req & ~empty;
    assign in_ready = reset | ~full | drain;
    assign in_data  = in_memToReg ? in_mem : in_alu;
    assign pending  = ~reset & ~empty;

    // XZR targets and non-writing results complete the handshake only
    assign push = ~reset & in_valid & in_ready & in_regWrite
                & (in_dest != 5'd31);

    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        if (!reset) begin
            if (ext_wr_req) begin
                RegWrite      = (ext_wr_reg != 5'd31);
                WriteRegister = ext_wr_reg;
                WriteData     = ext_wr_data;
            end else if (!empty) begin
                RegWrite      = 1'b1;
                WriteRegister = qdest[head];
                WriteData     = qdata[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (drain)
                head <= head + 1'b1;
            if (push && !drain)
                count <= count + 1'b1;
            else if (!push && drain)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qdest[tail] <= in_dest;
            qdata[tail] <= in_data;
        end
    end

    logic [4:0]        rreg [2];
    logic [DATA_W-1:0] rdat [2];
    logic [DATA_W-1:0] fwd  [2];
    logic [AW-1:0]     idx;

    assign rreg[0]  = ReadRegister1;
    assign rreg[1]  = ReadRegister2;
    assign rdat[0]  = RfData1;
    assign rdat[1]  = RfData2;
    assign FwdData1 = fwd[0];
    assign FwdData2 = fwd[1];

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        idx = head;
        for (int p = 0; p < 2; p++) begin
            fwd[p] = rdat[p];
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + AW'(i);
                if (((AW+1)'(i) < count) && (qdest[idx] == rreg[p]))
                    fwd[p] = qdata[idx];
            end
            if (ext_wr_req && (ext_wr_reg == rreg[p]))
                fwd[p] = ext_wr_data;
            if (rreg[p] == 5'd31)
                fwd[p] = '0;
            if (reset)
                fwd[p] = rdat[p];
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: directed vector table followed by random
// traffic checked against a queue-and-array model of the write side.
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_regWrite;
    logic [4:0]  in_dest;
    logic        in_memToReg;
    logic [63:0] in_alu;
    logic [63:0] in_mem;
    logic        ext_wr_req;
    logic [4:0]  ext_wr_reg;
    logic [63:0] ext_wr_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] RfData1;
    logic [63:0] RfData2;
    logic [63:0] FwdData1;
    logic [63:0] FwdData2;
    logic        pending;

    regfile_writer #(.DATA_W(64), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regWrite(in_regWrite), .in_dest(in_dest),
        .in_memToReg(in_memToReg), .in_alu(in_alu), .in_mem(in_mem),
        .ext_wr_req(ext_wr_req), .ext_wr_reg(ext_wr_reg),
        .ext_wr_data(ext_wr_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RfData1(RfData1), .RfData2(RfData2),
        .FwdData1(FwdData1), .FwdData2(FwdData2),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        int unsigned rst, vld, rw, dst, m2r, alu, mem;
        int unsigned ext, ereg, edat, r1, d1, r2, d2;
        int unsigned e_rw, e_wr, e_wd, e_rdy, e_pnd, e_f1, e_f2;
    } vec_t;

    vec_t tbl [22];

    typedef struct {
        int          dest;
        logic [63:0] data;
    } ent_t;

    ent_t        mq [$];
    logic [63:0] rf [32];

    logic        m_rst, m_vld, m_rw, m_m2r, m_ext;
    int          m_dst, m_ereg, m_r1, m_r2;
    logic [63:0] m_alu, m_mem, m_edat;

    function automatic logic [63:0] mfwd(input int r, input logic [63:0] d);
        if (m_rst) return d;
        if (r == 31) return 64'd0;
        if (m_ext && m_ereg == r) return m_edat;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].dest == r) return mq[i].data;
        return d;
    endfunction

    initial begin
        tbl = '{
            '{1,1,1,5,0,'h9,0,1,2,'h5,31,'h7,0,'h8,
              0,0,0,1,0,'h7,'h8},
            '{0,1,1,5,0,'h1234,'h9999,0,0,0,5,'h55,0,0,
              0,0,0,1,0,'h55,0},
            '{0,0,0,0,0,0,0,0,0,0,5,'h55,0,0,
              1,5,'h1234,1,1,'h1234,0},
            '{0,0,0,0,0,0,0,0,0,0,5,'h1234,0,0,
              0,0,0,1,0,'h1234,0},
            '{0,1,1,3,1,'hEE,'hA,0,0,0,3,0,0,0,
              0,0,0,1,0,0,0},
            '{0,1,1,3,0,'hB,0,0,0,0,3,0,0,0,
              1,3,'hA,1,1,'hA,0},
            '{0,0,0,0,0,0,0,0,0,0,3,'hA,0,0,
              1,3,'hB,1,1,'hB,0},
            '{0,0,0,0,0,0,0,0,0,0,3,'hB,0,0,
              0,0,0,1,0,'hB,0},
            '{0,1,1,7,0,'h70,0,1,20,'hE0,20,0,7,0,
              1,20,'hE0,1,0,'hE0,0},
            '{0,1,1,8,0,'h80,0,1,21,'hE1,7,0,8,0,
              1,21,'hE1,1,1,'h70,0},
            '{0,1,1,9,0,'h90,0,1,22,'hE2,8,0,22,0,
              1,22,'hE2,0,1,'h80,'hE2},
            '{0,1,1,9,0,'h90,0,0,0,0,7,0,9,0,
              1,7,'h70,1,1,'h70,0},
            '{0,0,0,0,0,0,0,0,0,0,9,0,8,0,
              1,8,'h80,1,1,'h90,'h80},
            '{0,0,0,0,0,0,0,0,0,0,9,0,0,0,
              1,9,'h90,1,1,'h90,0},
            '{0,0,0,0,0,0,0,0,0,0,9,'h90,0,0,
              0,0,0,1,0,'h90,0},
            '{0,1,0,4,0,1,0,0,0,0,0,0,31,'hFFFF,
              0,0,0,1,0,0,0},
            '{0,1,1,31,0,2,0,0,0,0,0,0,31,'hFFFF,
              0,0,0,1,0,0,0},
            '{0,0,0,0,0,0,0,0,0,0,4,'h3,31,'hFFFF,
              0,0,0,1,0,'h3,0},
            '{0,1,1,10,0,'hA0,0,1,0,'h11,0,'h5,0,'h5,
              1,0,'h11,1,0,'h11,'h11},
            '{0,1,1,11,0,'hB0,0,1,31,'h22,31,'h5,10,0,
              0,31,'h22,1,1,0,'hA0},
            '{1,0,0,0,0,0,0,0,0,0,10,'h3,11,'h4,
              0,0,0,1,0,'h3,'h4},
            '{0,0,0,0,0,0,0,0,0,0,10,'h3,11,'h4,
              0,0,0,1,0,'h3,'h4}
        };

        reset = 1'b1;
        in_valid = 1'b0; in_regWrite = 1'b0; in_dest = '0;
        in_memToReg = 1'b0; in_alu = '0; in_mem = '0;
        ext_wr_req = 1'b0; ext_wr_reg = '0; ext_wr_data = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        RfData1 = '0; RfData2 = '0;

        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            reset       = 1'(tbl[n].rst);
            in_valid    = 1'(tbl[n].vld);
            in_regWrite = 1'(tbl[n].rw);
            in_dest     = 5'(tbl[n].dst);
            in_memToReg = 1'(tbl[n].m2r);
            in_alu      = 64'(tbl[n].alu);
            in_mem      = 64'(tbl[n].mem);
            ext_wr_req  = 1'(tbl[n].ext);
            ext_wr_reg  = 5'(tbl[n].ereg);
            ext_wr_data = 64'(tbl[n].edat);
            ReadRegister1 = 5'(tbl[n].r1);
            RfData1     = 64'(tbl[n].d1);
            ReadRegister2 = 5'(tbl[n].r2);
            RfData2     = 64'(tbl[n].d2);
            #1;
            chk($sformatf("v%0d RegWrite", n), 64'(RegWrite),
                64'(tbl[n].e_rw));
            chk($sformatf("v%0d WriteRegister", n), 64'(WriteRegister),
                64'(tbl[n].e_wr));
            chk($sformatf("v%0d WriteData", n), WriteData,
                64'(tbl[n].e_wd));
            chk($sformatf("v%0d in_ready", n), 64'(in_ready),
                64'(tbl[n].e_rdy));
            chk($sformatf("v%0d pending", n), 64'(pending),
                64'(tbl[n].e_pnd));
            chk($sformatf("v%0d FwdData1", n), FwdData1,
                64'(tbl[n].e_f1));
            chk($sformatf("v%0d FwdData2", n), FwdData2,
                64'(tbl[n].e_f2));
        end

        for (int i = 0; i < 32; i++)
            rf[i] = {$urandom, $urandom};
        mq.delete();

        for (int n = 0; n < 3000; n++) begin
            logic        e_rw, e_rdy, e_pnd, e_drain;
            logic [4:0]  e_wr;
            logic [63:0] e_wd;
            @(negedge clk);
            m_rst  = (n == 0) || ($urandom_range(0, 63) == 0);
            m_vld  = ($urandom_range(0, 3) != 0);
            m_rw   = ($urandom_range(0, 7) != 0);
            m_dst  = $urandom_range(0, 16);
            if (m_dst == 16) m_dst = 31;
            m_m2r  = 1'($urandom_range(0, 1));
            m_alu  = {$urandom, $urandom};
            m_mem  = {$urandom, $urandom};
            m_ext  = ($urandom_range(0, 3) == 0);
            m_ereg = $urandom_range(16, 31);
            m_edat = {$urandom, $urandom};
            m_r1   = $urandom_range(0, 1) ? $urandom_range(0, 31)
                                          : $urandom_range(0, 16);
            m_r2   = $urandom_range(0, 31);

            reset = m_rst; in_valid = m_vld; in_regWrite = m_rw;
            in_dest = 5'(m_dst); in_memToReg = m_m2r;
            in_alu = m_alu; in_mem = m_mem;
            ext_wr_req = m_ext; ext_wr_reg = 5'(m_ereg);
            ext_wr_data = m_edat;
            ReadRegister1 = 5'(m_r1); RfData1 = rf[m_r1];
            ReadRegister2 = 5'(m_r2); RfData2 = rf[m_r2];

            e_rw = 1'b0; e_wr = '0; e_wd = '0; e_drain = 1'b0;
            if (m_rst) begin
                e_rdy = 1'b1; e_pnd = 1'b0;
            end else begin
                e_pnd   = (mq.size() != 0);
                e_drain = !m_ext && e_pnd;
                e_rdy   = (mq.size() < 2) || e_drain;
                if (m_ext) begin
                    e_rw = (m_ereg != 31); e_wr = 5'(m_ereg); e_wd = m_edat;
                end else if (e_pnd) begin
                    e_rw = 1'b1; e_wr = 5'(mq[0].dest); e_wd = mq[0].data;
                end
            end
            #1;
            chk($sformatf("r%0d RegWrite", n), 64'(RegWrite), 64'(e_rw));
            chk($sformatf("r%0d WriteRegister", n), 64'(WriteRegister),
                64'(e_wr));
            chk($sformatf("r%0d WriteData", n), WriteData, e_wd);
            chk($sformatf("r%0d in_ready", n), 64'(in_ready), 64'(e_rdy));
            chk($sformatf("r%0d pending", n), 64'(pending), 64'(e_pnd));
            chk($sformatf("r%0d FwdData1", n), FwdData1,
                mfwd(m_r1, rf[m_r1]));
            chk($sformatf("r%0d FwdData2", n), FwdData2,
                mfwd(m_r2, rf[m_r2]));

            if (m_rst) begin
                mq.delete();
            end else begin
                if (e_rw) rf[e_wr] = e_wd;
                if (e_drain) void'(mq.pop_front());
                if (m_vld && e_rdy && m_rw && m_dst != 31)
                    mq.push_back('{m_dst, m_m2r ? m_mem : m_alu});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
